// File: rtl/multiexp_fp2_feeder.sv
// multiexp_fp2_feeder: captures scalar/G2-point pairs into a buffer, then replays
// them KEY_BITS times as 7-beat packets for the Fp2 multiexp core.
module multiexp_fp2_feeder #(
    parameter type FE_TYPE  = logic [380:0],
    parameter int  KEY_BITS = 256,
    parameter int  CTL_BITS = 16,
    parameter int  MAX_IN   = 64
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_start,
    input  logic                             i_reload,
    input  logic [63:0]                      i_num_in,
    input  logic [CTL_BITS-1:0]              i_ctl,
    input  logic                             i_load_val,
    input  logic                             i_load_sop,
    input  logic                             i_load_eop,
    input  logic [$bits(FE_TYPE)-1:0]        i_load_dat,
    output logic                             o_load_rdy,
    output logic                             o_pnt_scl_val,
    output logic                             o_pnt_scl_sop,
    output logic                             o_pnt_scl_eop,
    output logic [$bits(FE_TYPE)-1:0]        o_pnt_scl_dat,
    output logic [CTL_BITS-1:0]              o_pnt_scl_ctl,
    output logic                             o_pnt_scl_mod,
    output logic                             o_pnt_scl_err,
    input  logic                             i_pnt_scl_rdy,
    output logic                             o_busy,
    output logic                             o_done,
    output logic                             o_err
);
    localparam int DAT_BITS = $bits(FE_TYPE);
    localparam int DEPTH    = MAX_IN * 7;
    localparam int AW       = $clog2(DEPTH);
    localparam int PW       = (KEY_BITS > 1) ? $clog2(KEY_BITS) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t              r_state, w_next;
    logic [DAT_BITS-1:0] r_mem [DEPTH];
    logic [DAT_BITS-1:0] r_q, r_sk_dat;
    logic [CTL_BITS-1:0] r_ctl;
    logic [AW-1:0]       r_tot, r_wr_addr, r_rd_addr;
    logic [2:0]          r_beat;
    logic [PW-1:0]       r_pass;
    logic r_buf_val, r_iss_done, r_pend, r_q_sop, r_q_eop, r_sk_val, r_sk_sop, r_sk_eop, r_err, r_done;
    logic w_start, w_bad, w_wr, w_frm_err, w_load_end, w_pop, w_pair_end, w_last_rd, w_issue, w_out_ld, w_fin;

    assign w_start    = r_state == IDLE && i_start;
    assign w_bad      = i_num_in == 64'd0 || i_num_in > 64'(MAX_IN) || (!i_reload && !r_buf_val);
    assign w_wr       = r_state == LOAD && i_load_val;
    assign w_frm_err  = w_wr && (i_load_sop != (r_beat == 3'd0) || i_load_eop != (r_beat == 3'd6));
    assign w_load_end = w_wr && r_wr_addr == r_tot - AW'(1);
    assign w_pop      = o_pnt_scl_val && i_pnt_scl_rdy;
    assign w_pair_end = r_rd_addr == r_tot - AW'(1);
    assign w_last_rd  = w_pair_end && r_pass == PW'(KEY_BITS - 1);
    // Reads are issued only when output register + skid can absorb the one in flight.
    assign w_issue    = r_state == RUN && !r_iss_done &&
                        (2'(o_pnt_scl_val) + 2'(r_sk_val) + 2'(r_pend) - 2'(w_pop)) < 2'd2;
    assign w_out_ld   = !o_pnt_scl_val || w_pop;
    assign w_fin      = r_state == RUN && r_iss_done && w_pop && !r_sk_val && !r_pend;

    assign o_load_rdy    = r_state == LOAD;
    assign o_busy        = r_state != IDLE;
    assign o_done        = r_done;
    assign o_err         = r_err;
    assign o_pnt_scl_ctl = r_ctl & ~CTL_BITS'(1);
    assign o_pnt_scl_mod = 1'b0;
    assign o_pnt_scl_err = 1'b0;

    always_comb begin
        w_next = r_state;
        if (w_start && !w_bad) w_next = i_reload ? LOAD : RUN;
        if (w_frm_err) w_next = IDLE;
        else if (w_load_end) w_next = RUN;
        if (w_fin) w_next = IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wr_addr] <= i_load_dat;
        r_q <= r_mem[r_rd_addr];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ctl         <= '0;
            r_tot         <= '0;
            r_wr_addr     <= '0;
            r_rd_addr     <= '0;
            r_beat        <= '0;
            r_pass        <= '0;
            r_buf_val     <= 1'b0;
            r_iss_done    <= 1'b0;
            r_pend        <= 1'b0;
            r_q_sop       <= 1'b0;
            r_q_eop       <= 1'b0;
            r_sk_val      <= 1'b0;
            r_sk_sop      <= 1'b0;
            r_sk_eop      <= 1'b0;
            r_sk_dat      <= '0;
            r_err         <= 1'b0;
            r_done        <= 1'b0;
            o_pnt_scl_val <= 1'b0;
            o_pnt_scl_sop <= 1'b0;
            o_pnt_scl_eop <= 1'b0;
            o_pnt_scl_dat <= '0;
        end else begin
            r_err  <= (w_start && w_bad) || w_frm_err;
            r_done <= w_fin;
            if (w_start && !w_bad) begin
                r_ctl      <= i_ctl;
                r_tot      <= AW'(i_num_in) * AW'(7);
                r_wr_addr  <= '0;
                r_rd_addr  <= '0;
                r_beat     <= '0;
                r_pass     <= '0;
                r_iss_done <= 1'b0;
                if (i_reload) r_buf_val <= 1'b0;
            end
            if (w_wr) begin
                r_wr_addr <= r_wr_addr + AW'(1);
                r_beat    <= r_beat == 3'd6 ? 3'd0 : r_beat + 3'd1;
            end
            if (w_frm_err) r_buf_val <= 1'b0;
            else if (w_load_end) r_buf_val <= 1'b1;
            if (w_issue) begin
                r_rd_addr  <= w_pair_end ? '0 : r_rd_addr + AW'(1);
                r_beat     <= r_beat == 3'd6 ? 3'd0 : r_beat + 3'd1;
                r_pass     <= w_pair_end ? r_pass + PW'(1) : r_pass;
                r_iss_done <= w_last_rd;
                r_q_sop    <= r_beat == 3'd0;
                r_q_eop    <= r_beat == 3'd6;
            end
            r_pend <= w_issue;
            if (r_pend) {r_sk_dat, r_sk_sop, r_sk_eop} <= {r_q, r_q_sop, r_q_eop};
            r_sk_val <= w_out_ld ? (r_sk_val && r_pend) : (r_sk_val || r_pend);
            if (w_out_ld) begin
                o_pnt_scl_val <= r_sk_val || r_pend;
                if (r_sk_val) {o_pnt_scl_dat, o_pnt_scl_sop, o_pnt_scl_eop} <= {r_sk_dat, r_sk_sop, r_sk_eop};
                else if (r_pend) {o_pnt_scl_dat, o_pnt_scl_sop, o_pnt_scl_eop} <= {r_q, r_q_sop, r_q_eop};
            end
        end
    end
endmodule

// File: tb/tb_multiexp_fp2_feeder.sv
// tb_multiexp_fp2_feeder: randomized self-checking bench; a loop-based model of the
// replay order predicts every output beat.
module tb_multiexp_fp2_feeder;
    localparam int KB = 4;
    localparam int MI = 4;

    typedef struct packed {logic [15:0] d; logic s; logic e;} beat_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic start = 1'b0, reload = 1'b0;
    logic [63:0] num_in = '0;
    logic [15:0] ctl = '0;
    logic ld_val = 1'b0, ld_sop = 1'b0, ld_eop = 1'b0, ld_rdy;
    logic [15:0] ld_dat = '0;
    logic val, sop, eop, mod, perr, rdy = 1'b1;
    logic [15:0] dat, octl;
    logic busy, done, err;

    int checks = 0, errors = 0, n_hs = 0, n_done = 0, cyc = 0;
    beat_t exp_q[$];
    logic [15:0] mdl_buf [MI*7];
    logic [15:0] job_ctl = '0;
    bit rnd_rdy = 0, gaps = 0, stalled = 0;
    logic [33:0] hold = '0;

    multiexp_fp2_feeder #(.FE_TYPE(logic [15:0]), .KEY_BITS(KB), .CTL_BITS(16), .MAX_IN(MI)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_reload(reload), .i_num_in(num_in),
        .i_ctl(ctl), .i_load_val(ld_val), .i_load_sop(ld_sop), .i_load_eop(ld_eop),
        .i_load_dat(ld_dat), .o_load_rdy(ld_rdy), .o_pnt_scl_val(val), .o_pnt_scl_sop(sop),
        .o_pnt_scl_eop(eop), .o_pnt_scl_dat(dat), .o_pnt_scl_ctl(octl), .o_pnt_scl_mod(mod),
        .o_pnt_scl_err(perr), .i_pnt_scl_rdy(rdy), .o_busy(busy), .o_done(done), .o_err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        rdy = rnd_rdy ? ($urandom_range(1, 0) == 1) : 1'b1;
    end

    always @(negedge clk) begin
        beat_t b;
        if (!rst_n) stalled = 0;
        else begin
            if (stalled) check("stall_hold", {dat, sop, eop, octl}, hold);
            if (val && rdy) begin
                n_hs++;
                if (exp_q.size() == 0) check("extra_beat", 1, 0);
                else begin
                    b = exp_q.pop_front();
                    check("dat", dat, b.d);
                    check("sop", sop, b.s);
                    check("eop", eop, b.e);
                    check("ctl", octl, {job_ctl[15:1], 1'b0});
                    check("mod_err", {mod, perr}, 0);
                end
            end
            if (done) n_done++;
            stalled = val && !rdy;
            hold = {dat, sop, eop, octl};
        end
    end

    task automatic plan(input int n, input logic [15:0] c);
        job_ctl = c;
        n_hs = 0;
        n_done = 0;
        for (int p = 0; p < KB; p++)
            for (int i = 0; i < n; i++)
                for (int w = 0; w < 7; w++)
                    exp_q.push_back({mdl_buf[i*7+w], w == 0, w == 6});
    endtask

    task automatic do_start(input bit rl, input int n, input logic [15:0] c);
        reload = rl;
        num_in = 64'(n);
        ctl = c;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic load(input int n, input int bad_eop_at);
        int t;
        cyc = 0;
        for (int k = 0; k < n*7; k++) begin
            ld_val = 1'b0;
            while (gaps && $urandom_range(2, 0) == 0) begin tick(); cyc++; end
            ld_val = 1'b1;
            ld_dat = mdl_buf[k];
            ld_sop = (k % 7 == 0);
            ld_eop = (k % 7 == 6) || (k == bad_eop_at);
            t = 0;
            while (!ld_rdy && t < 20) begin tick(); cyc++; t++; end
            if (!ld_rdy) begin
                check("load_rdy_timeout", 0, 1);
                break;
            end
            tick();
            cyc++;
            if (k == bad_eop_at) break;
        end
        ld_val = 1'b0;
        ld_sop = 1'b0;
        ld_eop = 1'b0;
    endtask

    task automatic wait_done(input int beats, input bit no_bubble);
        int c, first, span;
        c = 0; first = -1; span = 0;
        while (!done && c < 5000) begin
            if (val && first < 0) first = c;
            if (first >= 0) span++;
            tick();
            c++;
        end
        check("done_timeout", done, 1);
        check("busy_at_done", busy, 0);
        check("first_beat_lat", first, 2);
        if (no_bubble) check("no_bubble_span", span, beats);
        check("beat_count", n_hs, beats);
        check("exp_left", exp_q.size(), 0);
        tick();
        check("done_once", n_done, 1);
        check("done_pulse", done, 0);
    endtask

    task automatic reject(input bit rl, input int n);
        do_start(rl, n, 16'h0F0F);
        check("rej_err", err, 1);
        check("rej_busy_rdy", {busy, ld_rdy, val}, 0);
        tick();
        check("rej_err_pulse", {err, busy, ld_rdy}, 0);
    endtask

    initial begin
        for (int i = 0; i < MI*7; i++) mdl_buf[i] = '0;
        #23;
        check("rst_ctrl", {val, sop, eop, busy, done, err, ld_rdy}, 0);
        check("rst_data", {dat, octl}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        reject(0, 1);

        for (int i = 0; i < 14; i++) mdl_buf[i] = 16'(i + 1);
        plan(2, 16'hA5A5);
        do_start(1, 2, 16'hA5A5);
        check("load_busy_rdy", {busy, ld_rdy}, 2'b11);
        load(2, -1);
        check("load_cycles", cyc, 14);
        wait_done(56, 1);

        rnd_rdy = 1; gaps = 1;
        plan(2, 16'h3C5B);
        do_start(1, 2, 16'h3C5B);
        load(2, -1);
        wait_done(56, 0);
        rnd_rdy = 0; gaps = 0;

        plan(1, 16'h7E01);
        do_start(0, 1, 16'h7E01);
        check("replay_busy_nordy", {busy, ld_rdy}, 2'b10);
        wait_done(28, 1);

        reject(1, 0);
        reject(1, 5);

        for (int i = 0; i < 14; i++) mdl_buf[i] = 16'($urandom);
        do_start(1, 2, 16'h1111);
        load(2, 4);
        check("frm_err", err, 1);
        check("frm_idle", {busy, ld_rdy, val}, 0);
        tick();
        reject(0, 1);

        for (int i = 0; i < 14; i++) mdl_buf[i] = 16'($urandom);
        plan(2, 16'hBEEF);
        do_start(1, 2, 16'hBEEF);
        load(2, -1);
        for (int t = 0; t < 200 && n_hs < 20; t++) tick();
        check("reach_beat20", n_hs >= 20, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ctrl", {val, sop, eop, busy, done, err, ld_rdy}, 0);
        check("arst_data", {dat, octl}, 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        reject(0, 1);

        rnd_rdy = 1; gaps = 1;
        for (int i = 0; i < 21; i++) mdl_buf[i] = 16'($urandom);
        plan(3, 16'($urandom));
        do_start(1, 3, job_ctl);
        load(3, -1);
        wait_done(84, 0);
        rnd_rdy = 0; gaps = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multiexp_fp2_feeder.md
# multiexp_fp2_feeder

Stream source that sits directly upstream of the Fp2 multiexp core. Phase one captures NUM_IN scalar/G2-point pairs from a loader stream into an internal buffer. Phase two replays the whole set KEY_BITS times as 7-beat FE_TYPE-wide packets, in the looping order the core consumes. All output packets carry ctl[0]=0, which selects the core's normal (double-and-add) mode.

## Interface
Parameters:
- FE_TYPE, none: base field element type. DAT_BITS = $bits(FE_TYPE).
- KEY_BITS, 256: scalar bit count, equal to the number of replay passes.
- CTL_BITS, 16: ctl width on both streams.
- MAX_IN, 64: buffer capacity in pairs. Buffer depth is MAX_IN*7 words.

Ports:
- i_clk, in, 1: clock.
- i_rst_n, in, 1: asynchronous active-low reset.
- i_start, in, 1: start a job. Sampled only in IDLE.
- i_reload, in, 1: sampled with i_start. 1 = LOAD then RUN. 0 = RUN on the stored buffer.
- i_num_in, in, 64: pair count, sampled with i_start.
- i_ctl, in, CTL_BITS: tag, sampled with i_start. Bits [CTL_BITS-1:1] are copied to every output beat.
- i_load_if, sink, if_axi_stream DAT_BITS/CTL_BITS: loader stream. 7 beats per pair, scalar first, then point words 0..5. sop on beat 0, eop on beat 6.
- o_pnt_scl_if, source, if_axi_stream DAT_BITS/CTL_BITS: 7-beat packets to the core.
- o_busy, out, 1: high whenever state ≠ IDLE.
- o_done, out, 1: one-cycle pulse after the final output beat is accepted.
- o_err, out, 1: one-cycle pulse on a rejected start or a load framing error.

## Operation
- States: IDLE, LOAD, RUN.
- IDLE, on i_start:
  - If num_in==0, num_in>MAX_IN, or (i_reload=0 and no valid buffer): pulse o_err and stay in IDLE.
  - Otherwise latch num_in and ctl, clear counters, and go to LOAD if i_reload=1, else RUN.
- LOAD:
  - i_load_if.rdy=1. Each accepted beat is written to buf[wr_addr], and wr_addr increments.
  - beat_cnt (0..6) tracks position within a pair.
  - Framing error: sop≠(beat_cnt==0) or eop≠(beat_cnt==6). On error, pulse o_err, clear the buffer-valid flag, and return to IDLE. The offending beat is still accepted.
  - When wr_addr reaches num_in*7, set buffer-valid and go to RUN.
- RUN:
  - Read address = pair_cnt*7 + beat_cnt.
  - Output beat fields: dat=buf[addr], sop=(beat_cnt==0), eop=(beat_cnt==6), ctl={ctl[CTL_BITS-1:1],1'b0}, mod=0, err=0.
  - Counter wrap order:
    - beat_cnt wraps 6→0 and increments pair_cnt.
    - pair_cnt wraps num_in-1→0 and increments pass_cnt.
    - pass_cnt == KEY_BITS-1 with pair and beat at their last values ends the job.
  - Total beats = KEY_BITS*num_in*7.
  - After the final beat handshake: pulse o_done, go to IDLE. The buffer stays valid.
- i_load_if.rdy=0 outside LOAD. i_start is ignored outside IDLE.
- Reset, including mid-operation: state=IDLE, counters=0, buffer-valid=0. Buffer RAM contents are not cleared.

## Timing
- Reset values: i_load_if.rdy=0, o_pnt_scl_if.val/sop/eop/dat/ctl=0, o_busy=0, o_done=0, o_err=0.
- i_start accepted at cycle T: o_busy=1 and, if reloading, i_load_if.rdy=1 from T+1. A rejected start pulses o_err at T+1.
- Buffer read latency is 1 cycle. The first RUN beat has val=1 two cycles after RUN entry.
- Throughput: one beat per cycle while o_pnt_scl_if.rdy=1. No bubbles at packet, pair-wrap or pass-wrap boundaries.
- Backpressure:
  - The output register holds dat/ctl/sop/eop stable while val=1 and rdy=0.
  - A 1-entry skid holds the in-flight RAM read, so rdy may toggle every cycle without beat loss or duplication.
- o_done is asserted the cycle after the last handshake, together with o_busy=0.
- LOAD throughput: one beat per cycle. A load of num_in*7 beats takes exactly num_in*7 cycles with val held high.

## Test plan
- KEY_BITS=4, MAX_IN=4, num_in=2, reload. Load words 1..14 -> 56 output beats, dat sequence 1..14 repeated 4×, sop every 7th beat from beat 0, eop on beats 6,13,..., o_done once.
- Same job with random o_pnt_scl_if.rdy (50%) and random i_load_if.val gaps -> identical 56-beat sequence, no drop or duplicate, dat stable under stall.
- Replay with i_reload=0, num_in=1 after the test above -> 28 beats of words 1..7 with no load phase. The same start after reset -> o_err pulse, o_busy stays 0.
- num_in=0, then num_in=5 (>MAX_IN) -> o_err pulse each, no rdy, no output.
- Load with eop on beat 4 -> o_err, return to IDLE, no output. A following i_reload=0 start -> o_err.
- Assert i_rst_n low during RUN at beat 20 -> all outputs 0 asynchronously. After release, a new reload job runs cleanly.
